// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and parity mode constants.
package uart_pkg;

  localparam int unsigned STATE_W = 3;

  // Parity modes
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Ports: clk, rst (async active-high), d (async input), q (synchronised output).
// Both flops reset to RST_VAL so the output is defined during reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_uart_param.sv
// Parameterised UART receiver: start-bit mid-point qualification, LSB-first data,
// optional parity, one or two stop bits, and break hold-off after a framing error.
// Ports: clk, rst (async active-high), rx (async serial line, idle high),
//        data_out (last word), valid (one-cycle frame-complete strobe),
//        parity_err, frame_err (flags of last frame), busy (not IDLE),
//        state_out (current state encoding).
module rx_uart_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 27000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [STATE_W-1:0]   state_out
);

  localparam int unsigned CPB   = CLK_HZ / BAUD;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned IDX_W = 4;

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY > 2 || CPB < 8) begin : g_bad_params
    $fatal(1, "rx_uart_param: illegal parameter set");
  end

  logic                 rx_s;
  rx_state_e            state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 ferr_acc;

  logic tick_c, sample_c, last_data_c, last_stop_c, ferr_c, perr_c, done_c;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Sample timing and frame-result decode; START samples at mid-bit, others one bit later
  always_comb begin
    tick_c      = 1'b0;
    sample_c    = 1'b0;
    last_data_c = 1'b0;
    last_stop_c = 1'b0;
    ferr_c      = 1'b0;
    perr_c      = 1'b0;
    done_c      = 1'b0;
    tick_c      = (state == ST_START) ? (cnt == CNT_W'(HALF - 1)) : (cnt == CNT_W'(CPB - 1));
    sample_c    = tick_c && (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
    last_data_c = (idx == IDX_W'(DATA_BITS - 1));
    last_stop_c = (idx == IDX_W'(STOP_BITS - 1));
    ferr_c      = ferr_acc | ~rx_s;
    if (PARITY != PAR_NONE)
      perr_c = ((^shift) ^ par_bit) != (PARITY == PAR_ODD);
    done_c      = sample_c && (state == ST_STOP) && last_stop_c;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (!rx_s) state_nx = ST_START;
      ST_START:  if (sample_c) state_nx = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (sample_c && last_data_c)
                   state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (sample_c) state_nx = ST_STOP;
      // Leave STOP right after the last sample so a gapless next start is seen
      ST_STOP:   if (done_c) state_nx = (ferr_c && !rx_s) ? ST_BREAK : ST_IDLE;
      ST_BREAK:  if (rx_s) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Datapath: bit timer, bit index, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      ferr_acc   <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= done_c;
      busy  <= (state_nx != ST_IDLE);

      if (state == ST_IDLE || state == ST_BREAK || sample_c) cnt <= '0;
      else                                                    cnt <= cnt + CNT_W'(1);

      if (sample_c && ((state == ST_DATA && !last_data_c) || (state == ST_STOP && !last_stop_c)))
        idx <= idx + IDX_W'(1);
      else if (sample_c || state == ST_IDLE)
        idx <= '0;

      if (sample_c && state == ST_DATA)   shift   <= {rx_s, shift[DATA_BITS-1:1]};
      if (sample_c && state == ST_PARITY) par_bit <= rx_s;

      if (sample_c && state == ST_START)     ferr_acc <= 1'b0;
      else if (sample_c && state == ST_STOP) ferr_acc <= ferr_c;

      if (done_c) begin
        data_out   <= shift;
        parity_err <= perr_c;
        frame_err  <= ferr_c;
      end
    end
  end

  assign state_out = state;

endmodule
